// File: rtl/mode_power_pkg.sv
// Shared state encoding and sizing helpers for the mode/power ramp block.
// Default-configuration constants are kept here; instances derive their own from parameters.
package mode_power_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int DEF_POW_W    = 4;
  localparam int DEF_RAMP_DIV = 4;
  localparam int DEF_PMAX     = (2 ** DEF_POW_W) - 1;
  localparam int DEF_CNT_W    = $clog2(DEF_RAMP_DIV + 1);

  function automatic int pmax_of(input int pow_w);
    return (2 ** pow_w) - 1;
  endfunction

  function automatic int cnt_w_of(input int ramp_div);
    return $clog2(ramp_div + 1);
  endfunction

endpackage

// File: rtl/mode_power_ramp_popcount.sv
// Combinational population count of an IN_W-bit field, saturated to the
// largest value representable in OUT_W bits.
module popcount_sat #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  in_bits,
  output logic [OUT_W-1:0] sat_out
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int MW = (CW > OUT_W) ? CW : OUT_W;

  // Prefix-sum chain; CW bits always holds IN_W so the count never wraps.
  logic [CW-1:0] psum [0:IN_W];

  assign psum[0] = '0;

  generate
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_sum
      assign psum[gi+1] = psum[gi] + CW'(in_bits[gi]);
    end
  endgenerate

  logic [MW-1:0] count_ext;
  logic [MW-1:0] limit_ext;

  assign count_ext = MW'(psum[IN_W]);
  assign limit_ext = MW'({OUT_W{1'b1}});
  assign sat_out   = (count_ext > limit_ext) ? {OUT_W{1'b1}} : OUT_W'(psum[IN_W]);

endmodule

// File: rtl/mode_power_ramp.sv
// Decodes a channel configuration word into mode + target power and drives a
// registered power level toward it, either directly or one step per RAMP_DIV cycles.
module mode_power_ramp
  import mode_power_pkg::*;
#(
  parameter int CONF_W   = 8,
  parameter int POW_W    = 4,
  parameter int RAMP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CONF_W-1:0] chs_conf,
  input  logic              conf_valid,
  output logic              conf_ready,
  input  logic              force_off,
  output logic [POW_W-1:0]  chs_power,
  output logic              chs_mode,
  output logic              power_done
);

  localparam int PMAX  = pmax_of(POW_W);
  localparam int CNT_W = cnt_w_of(RAMP_DIV);

  localparam logic [POW_W-1:0] PMAX_V    = POW_W'(PMAX);
  localparam logic [POW_W-1:0] ONE_P     = POW_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t             state_reg,  state_next;
  logic [POW_W-1:0]   power_reg,  power_next;
  logic [POW_W-1:0]   target_reg, target_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic               mode_reg,   mode_next;

  logic               conf_mode;
  logic [POW_W-1:0]   req;

  assign conf_mode = chs_conf[CONF_W-1];

  popcount_sat #(
    .IN_W  (CONF_W - 1),
    .OUT_W (POW_W)
  ) u_popcount (
    .in_bits (chs_conf[CONF_W-2:0]),
    .sat_out (req)
  );

  assign conf_ready = (state_reg == IDLE) && !force_off;
  assign chs_power  = power_reg;
  assign chs_mode   = mode_reg;
  assign power_done = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      power_reg  <= '0;
      target_reg <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      power_reg  <= power_next;
      target_reg <= target_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    power_next  = power_reg;
    target_next = target_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;

    if (force_off) begin
      // Emergency off wins over any handshake or ramp; mode is deliberately kept.
      state_next  = IDLE;
      power_next  = '0;
      target_next = '0;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (conf_valid) begin
            mode_next   = conf_mode;
            target_next = req;
            cnt_next    = '0;
            if (req == power_reg) begin
              state_next = DONE;
            end else if (!conf_mode) begin
              power_next = req;
              state_next = DONE;
            end else if (req > power_reg) begin
              state_next = RAMP_UP;
            end else begin
              state_next = RAMP_DOWN;
            end
          end
        end

        RAMP_UP: begin
          if (power_reg == target_reg || power_reg == PMAX_V) begin
            state_next = DONE;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            power_next = power_reg + ONE_P;
            if (power_reg + ONE_P == target_reg) begin
              state_next = DONE;
            end
          end else begin
            cnt_next = cnt_reg + ONE_C;
          end
        end

        RAMP_DOWN: begin
          if (power_reg == target_reg || power_reg == '0) begin
            state_next = DONE;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            power_next = power_reg - ONE_P;
            if (power_reg - ONE_P == target_reg) begin
              state_next = DONE;
            end
          end else begin
            cnt_next = cnt_reg + ONE_C;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
